// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase sequencer: FSM states, phase width,
// direction encodings and the modulo-4 phase step.
package phase_seq_pkg;

   localparam int unsigned PHASE_W = 2;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic {
      IDLE,
      DWELL
   } state_e;

   function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] phase,
                                                     input logic               dir);
      return (dir == DIR_DOWN) ? phase - PHASE_W'(1) : phase + PHASE_W'(1);
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell down-counter: load takes priority over decrement; clear wins over both.
module dwell_timer #(
   parameter int unsigned DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               dec_i,
   input  logic               clr_i,
   input  logic [DWELL_W-1:0] load_val_i,
   output logic               zero_o
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (dec_i)
         cnt_d = cnt_q - DWELL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Steps a 2-bit phase {a,b} through 0..3 with a programmable dwell per phase,
// in free-running up/down or single-step mode; emits registered tick/wrap.
module phase_sequencer
   import phase_seq_pkg::*;
#(
   parameter int unsigned DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               dir,
   input  logic               step_mode,
   input  logic               step_req,
   input  logic [DWELL_W-1:0] dwell,
   output logic               a,
   output logic               b,
   output logic               tick,
   output logic               wrap,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               tick_q, tick_d;
   logic               wrap_q, wrap_d;
   logic               adv, cnt_load, cnt_dec, cnt_clr, cnt_zero;

   dwell_timer #(
      .DWELL_W(DWELL_W)
   ) u_dwell_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (cnt_load),
      .dec_i     (cnt_dec),
      .clr_i     (cnt_clr),
      .load_val_i(dwell),
      .zero_o    (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next state plus the advance and counter controls shared with the timer.
   always_comb begin
      state_d  = state_q;
      adv      = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (step_mode && step_req) begin
               adv = 1'b1;
            end else if (!step_mode && en) begin
               cnt_load = 1'b1;
               state_d  = DWELL;
            end
         end
         DWELL: begin
            if (!en || step_mode) begin
               cnt_clr = 1'b1;
               state_d = IDLE;
            end else if (cnt_zero) begin
               adv      = 1'b1;
               cnt_load = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      phase_d = phase_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (adv) begin
         phase_d = next_phase(phase_q, dir);
         tick_d  = 1'b1;
         wrap_d  = (dir == DIR_DOWN) ? (phase_q == '0) : (phase_q == '1);
      end
   end

   assign a    = phase_q[1];
   assign b    = phase_q[0];
   assign tick = tick_q;
   assign wrap = wrap_q;
   assign busy = (state_q == DWELL);

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios then random stimulus, all checked
// against a cycle-scheduled reference model (advance due at load/advance edge + dwell + 1).
module tb_phase_sequencer;

   localparam int unsigned DW = 4;

   logic          clk = 1'b0;
   logic          rst, en, dir, step_mode, step_req;
   logic [DW-1:0] dwell;
   logic          a, b, tick, wrap, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   // Reference model state
   int m_phase;
   bit m_run;
   int m_due;
   bit m_tick, m_wrap;

   phase_sequencer #(
      .DWELL_W(DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .step_mode(step_mode),
      .step_req (step_req),
      .dwell    (dwell),
      .a        (a),
      .b        (b),
      .tick     (tick),
      .wrap     (wrap),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, edge_n);
      end
   endtask

   task automatic model_advance();
      m_wrap  = dir ? (m_phase == 0) : (m_phase == 3);
      m_phase = (m_phase + (dir ? 3 : 1)) % 4;
      m_tick  = 1'b1;
   endtask

   task automatic model_edge();
      m_tick = 1'b0;
      m_wrap = 1'b0;
      if (rst) begin
         m_phase = 0;
         m_run   = 1'b0;
      end else if (!m_run) begin
         if (step_mode && step_req) begin
            model_advance();
         end else if (!step_mode && en) begin
            m_run = 1'b1;
            m_due = edge_n + int'(dwell) + 1;
         end
      end else if (!en || step_mode) begin
         m_run = 1'b0;
      end else if (edge_n == m_due) begin
         model_advance();
         m_due = edge_n + int'(dwell) + 1;
      end
   endtask

   task automatic clk_check();
      @(posedge clk);
      edge_n++;
      model_edge();
      #1;
      check_eq("phase", 32'({a, b}), 32'(m_phase));
      check_eq("tick",  32'(tick),   32'(m_tick));
      check_eq("wrap",  32'(wrap),   32'(m_wrap));
      check_eq("busy",  32'(busy),   32'(m_run));
   endtask

   initial begin
      int exp_edge[4];
      int exp_ph[4];
      exp_edge = '{4, 7, 10, 13};
      exp_ph   = '{1, 2, 3, 0};

      rst = 1'b1; en = 1'b0; dir = 1'b0; step_mode = 1'b0; step_req = 1'b0; dwell = '0;
      m_phase = 0; m_run = 1'b0; m_due = 0; m_tick = 1'b0; m_wrap = 1'b0;

      // Reset held for two cycles
      clk_check();
      clk_check();
      check_eq("reset_F0", 32'({a, b} == 2'd0), 32'd1);

      // Free-run up, dwell=2: advances at edges 4,7,10,13 after the load edge
      rst = 1'b0; en = 1'b1; dwell = DW'(2); dir = 1'b0;
      for (int e = 1; e <= 13; e++) begin
         clk_check();
         for (int k = 0; k < 4; k++)
            if (e == exp_edge[k]) check_eq("freerun_phase", 32'({a, b}), 32'(exp_ph[k]));
         if (e == 13) check_eq("freerun_wrap", 32'(wrap), 32'd1);
         if (e == 1)  check_eq("freerun_busy", 32'(busy), 32'd1);
      end

      // Down with dwell=0: advance on every edge
      en = 1'b0;
      clk_check();
      en = 1'b1; dir = 1'b1; dwell = '0;
      for (int e = 0; e < 7; e++) clk_check();

      // Single-step pulses
      en = 1'b0; step_mode = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step_req = (c == 5 || c == 9);
         clk_check();
      end
      step_req = 1'b0;

      // Stop mid-dwell, then restart the full wait
      step_mode = 1'b0; dir = 1'b0; dwell = DW'(5); en = 1'b1;
      for (int c = 0; c < 3; c++) clk_check();
      en = 1'b0;
      for (int c = 0; c < 3; c++) clk_check();
      en = 1'b1;
      for (int c = 0; c < 14; c++) clk_check();

      // Reset mid-operation, including on an edge where an advance is due
      dwell = DW'(3);
      for (int c = 0; c < 9; c++) clk_check();
      rst = 1'b1;
      clk_check();
      rst = 1'b0; dwell = '0;
      clk_check();
      rst = 1'b1;
      clk_check();
      check_eq("reset_wins_tick", 32'(tick), 32'd0);
      rst = 1'b0;

      // Random stimulus
      for (int c = 0; c < 4000; c++) begin
         rst      = ($urandom_range(0, 99) == 0);
         en       = ($urandom_range(0, 9) != 0);
         step_req = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) step_mode = ~step_mode;
         if ($urandom_range(0, 7) == 0)  dir = ~dir;
         if ($urandom_range(0, 15) == 0)
            dwell = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15))
                                                : DW'($urandom_range(0, 3));
         clk_check();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
